clear_sequencer: RTL and testbench
==================================

Name: clear_sequencer

Overview:
- Staged clear/reset sequencer for banks of falling-edge, async-clear registers in the Gowin primitive library.
- Drives each bank's CLEAR pin from one controller:
  - holds all banks cleared for a programmable time;
  - then releases banks one at a time, lowest index first, with a fixed gap between releases.
- Runs automatically after RESET. Can be re-triggered by a soft request.

Parameters:
- NUM_STAGES, 4, number of banks / CLEAR outputs; legal 1..16.
- HOLD_CYCLES, 8, cycles all CLEAR bits stay high after the last cycle with RESET or REQ high; legal >= 1.
- GAP_CYCLES, 2, cycles between successive stage releases, and after the last release before DONE; legal >= 1.
- CNT_W, 8, timer width; must hold max(HOLD_CYCLES, GAP_CYCLES)-1.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  reset, synchronous, active-high.
- REQ  input  1  soft clear request, level-sensitive.
- CLEAR  output  NUM_STAGES  bit i drives CLEAR of bank i; 1 = bank held cleared.
- BUSY  output  1  high while a sequence is in progress.
- DONE  output  1  one-cycle pulse when a sequence completes.
- STAGE  output  4  index of the most recently released stage; 0 in ASSERT and IDLE.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high, named RESET. All outputs are registered.
- RESET sampled high gives, after that edge: state=ASSERT, CLEAR=all ones, BUSY=1, DONE=0, STAGE=0, timer=0. RESET has priority over REQ and over any state.
- States: ASSERT, RELEASE, IDLE.
- ASSERT:
  - CLEAR all ones; timer increments each cycle.
  - REQ high: timer reloads to 0.
  - timer==HOLD_CYCLES-1 with REQ low: go to RELEASE, stage=0, timer=0, CLEAR[0] clears on that edge.
- RELEASE:
  - CLEAR[j]=0 for j<=stage, 1 for j>stage; STAGE=stage; timer increments.
  - timer==GAP_CYCLES-1 and stage<NUM_STAGES-1: stage++, timer=0, CLEAR[stage+1] drops.
  - timer==GAP_CYCLES-1 and stage==NUM_STAGES-1: go to IDLE, BUSY=0, DONE=1 for exactly that one following cycle, STAGE=0.
- IDLE:
  - CLEAR all zero, BUSY=0, DONE=0 except the completion pulse.
  - REQ high: ASSERT next edge with CLEAR all ones, BUSY=1, timer=0.
- REQ high in RELEASE: abort. Next edge gives ASSERT, CLEAR all ones, stage=0, timer=0. Already-released banks are re-cleared.
- REQ held high keeps the block in ASSERT indefinitely.
- REQ high in the same cycle the DONE pulse is output: DONE still pulses, and ASSERT starts on the next edge.
- Latency: BUSY spans exactly HOLD_CYCLES + NUM_STAGES*GAP_CYCLES cycles when REQ stays low.
- CLEAR bits change only on CLK edges, so no glitch reaches the async CLEAR pins. Only one bit changes per edge, except full reassert.
- NUM_STAGES=1: a single release, then GAP_CYCLES cycles, then DONE.
- Timer is width CNT_W. Comparisons are against parameter-derived constants; no wrap occurs with legal parameters.

Decomposition:
- Shared package/include holds:
  - state encoding localparams ST_ASSERT=2'd0, ST_RELEASE=2'd1, ST_IDLE=2'd2;
  - a clog2-style width helper for STAGE/timer sizing.
- One natural sub-module, seq_timer:
  - inputs CLK, RESET, LOAD (clear to 0), parameter LIMIT;
  - outputs count and a terminal flag (count==LIMIT-1).
  - Instantiated once, with LIMIT muxed by state.
- Remaining logic is the FSM plus the CLEAR/STAGE register.

Test Plan:
1. Power-on sequence with defaults, RESET high for 2 cycles, released before cycle 0 -> CLEAR=1111 in cycles 0-7; 1110 in 8-9; 1100 in 10-11; 1000 in 12-13; 0000 from 14; BUSY=1 in 0-15; DONE=1 only in cycle 16; STAGE=0,1,2,3 aligned with the releases.
2. Soft request from IDLE: REQ high for 1 cycle in cycle c -> CLEAR=1111 from c+1; the same 16-cycle release pattern follows; DONE at c+17.
3. Abort mid-release: REQ pulsed while CLEAR=1100 -> CLEAR=1111 and STAGE=0 next cycle; full HOLD_CYCLES counted from the REQ deassert; full sequence completes.
4. REQ held for 20 cycles in ASSERT -> CLEAR stays 1111 and BUSY=1 throughout; first release exactly 8 cycles after REQ falls.
5. RESET asserted in RELEASE and in IDLE -> next cycle CLEAR=1111, BUSY=1, DONE=0. RESET overriding a simultaneous REQ gives identical results.
6. Parameter corner NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1 -> CLEAR=1 in cycle 0, 0 in cycle 1, DONE in cycle 2; BUSY high for exactly 2 cycles.

Source files
------------

// File: rtl/clear_sequencer_pkg.sv
// Shared definitions for the staged bank-clear sequencer.
package clear_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  // Width of the external STAGE port; sixteen banks at most.
  localparam int STAGE_PORT_W = 4;

  // Bits needed to index 0..count-1, never less than one.
  function automatic int width_for(input int count);
    int w;
    w = 1;
    while ((1 << w) < count) w++;
    return w;
  endfunction

endpackage

// File: rtl/clear_sequencer_timer.sv
// Cycle timer: restarts from zero on LOAD, flags the cycle where count hits last.
module seq_timer
  import clear_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  // Count up every cycle; a load or reset restarts the interval at zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (LOAD) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == last);

endmodule

// File: rtl/clear_sequencer.sv
// Holds every bank cleared for a while, then releases them one by one.
module clear_sequencer
  import clear_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ,
  output logic [NUM_STAGES-1:0]   CLEAR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [STAGE_PORT_W-1:0] STAGE
);

  localparam int SW = width_for(NUM_STAGES);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [SW-1:0]           stage_q;
  logic [SW-1:0]           stage_d;
  logic [CNT_W-1:0]        timer_last;
  logic [CNT_W-1:0]        timer_count;
  logic                    timer_load;
  logic                    timer_done;
  logic [NUM_STAGES-1:0]   clear_d;
  logic                    busy_d;
  logic                    done_d;
  logic [STAGE_PORT_W-1:0] stage_out_d;

  // The hold interval and the release gap share one timer; any state change,
  // any request, and the idle state all restart it so it never wraps.
  assign timer_last = (state_q == ST_ASSERT) ? HOLD_LAST : GAP_LAST;
  assign timer_load = REQ || timer_done || (state_q == ST_IDLE);

  seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .LOAD     (timer_load),
    .last     (timer_last),
    .count    (timer_count),
    .terminal (timer_done)
  );

  // State, stage and every output are registered so the async CLEAR pins only move on edges.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_ASSERT;
      stage_q <= '0;
      CLEAR   <= '1;
      BUSY    <= 1'b1;
      DONE    <= 1'b0;
      STAGE   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      CLEAR   <= clear_d;
      BUSY    <= busy_d;
      DONE    <= done_d;
      STAGE   <= stage_out_d;
    end
  end

  // A request always sends us back to a full hold; otherwise the timer paces the releases.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      ST_ASSERT: begin
        stage_d = '0;
        if (!REQ && timer_done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (REQ) begin
          state_d = ST_ASSERT;
          stage_d = '0;
        end else if (timer_done) begin
          if (stage_q == LAST_STAGE) begin
            state_d = ST_IDLE;
            stage_d = '0;
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end
      end
      ST_IDLE: begin
        stage_d = '0;
        if (REQ) begin
          state_d = ST_ASSERT;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        stage_d = '0;
      end
    endcase
  end

  // Output values for the next cycle, derived from where the FSM is heading.
  always_comb begin
    clear_d     = '0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_RELEASE) && (state_d == ST_IDLE);
    stage_out_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      clear_d[i] = (state_d == ST_ASSERT) ||
                   ((state_d == ST_RELEASE) && (i > int'(stage_d)));
    end
    if (state_d == ST_RELEASE) begin
      stage_out_d = STAGE_PORT_W'(stage_d);
    end
  end

  // Guard against the timer running past its interval, which would mean a missed reload.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      assert (timer_count <= timer_last);
    end
  end

endmodule

// File: tb/tb_clear_sequencer.sv
// Self-checking bench: a default-sized sequencer and a minimal 1/1/1 corner instance,
// both compared every cycle against an elapsed-time reference model.
module tb_clear_sequencer;

  localparam int N0 = 4;
  localparam int H0 = 8;
  localparam int G0 = 2;
  localparam int N1 = 1;
  localparam int H1 = 1;
  localparam int G1 = 1;

  logic       clk = 1'b0;
  logic       reset0;
  logic       req0;
  logic       reset1;
  logic       req1;
  logic [3:0] clear0;
  logic       busy0;
  logic       done0;
  logic [3:0] stage0;
  logic [0:0] clear1;
  logic       busy1;
  logic       done1;
  logic [3:0] stage1;

  int checkCount = 0;
  int errorCount = 0;
  int cycleNo    = 0;
  int k0         = 0;
  int k1         = 0;
  bit valid0     = 1'b0;
  bit valid1     = 1'b0;
  int burst      = 0;

  always #5 clk = ~clk;

  clear_sequencer #(
    .NUM_STAGES (N0),
    .HOLD_CYCLES(H0),
    .GAP_CYCLES (G0),
    .CNT_W      (8)
  ) dut (
    .CLK  (clk),
    .RESET(reset0),
    .REQ  (req0),
    .CLEAR(clear0),
    .BUSY (busy0),
    .DONE (done0),
    .STAGE(stage0)
  );

  clear_sequencer #(
    .NUM_STAGES (N1),
    .HOLD_CYCLES(H1),
    .GAP_CYCLES (G1),
    .CNT_W      (4)
  ) dut_small (
    .CLK  (clk),
    .RESET(reset1),
    .REQ  (req1),
    .CLEAR(clear1),
    .BUSY (busy1),
    .DONE (done1),
    .STAGE(stage1)
  );

  // Reference model: k is the number of cycles since the last cycle with RESET or REQ high.
  function automatic logic [31:0] expClear(input int k, input int n, input int h, input int g);
    logic [31:0] ones;
    int rel;
    ones = (32'd1 << n) - 32'd1;
    if (k < h) return ones;
    rel = (k - h) / g + 1;
    if (rel >= n) return 32'd0;
    return ones & ~((32'd1 << rel) - 32'd1);
  endfunction

  function automatic logic [31:0] expStage(input int k, input int n, input int h, input int g);
    if (k < h || k >= h + n * g) return 32'd0;
    return 32'((k - h) / g);
  endfunction

  function automatic logic [31:0] expBusy(input int k, input int n, input int h, input int g);
    return (k < h + n * g) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] expDone(input int k, input int n, input int h, input int g);
    return (k == h + n * g) ? 32'd1 : 32'd0;
  endfunction

  function automatic int nextK(input int k, input logic r, input logic q, input int total);
    if (r || q) return 0;
    return (k <= total) ? k + 1 : k;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cycleNo, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check on the falling edge.
  task automatic applyStimulus(input logic r0, input logic q0, input logic r1, input logic q1);
    reset0 = r0;
    req0   = q0;
    reset1 = r1;
    req1   = q1;
    @(posedge clk);
    if (r0) valid0 = 1'b1;
    if (r1) valid1 = 1'b1;
    k0 = nextK(k0, r0, q0, H0 + N0 * G0);
    k1 = nextK(k1, r1, q1, H1 + N1 * G1);
    @(negedge clk);
    cycleNo++;
    if (valid0) begin
      checkOutput("clear", 32'(clear0), expClear(k0, N0, H0, G0));
      checkOutput("busy",  32'(busy0),  expBusy(k0, N0, H0, G0));
      checkOutput("done",  32'(done0),  expDone(k0, N0, H0, G0));
      checkOutput("stage", 32'(stage0), expStage(k0, N0, H0, G0));
    end
    if (valid1) begin
      checkOutput("small_clear", 32'(clear1), expClear(k1, N1, H1, G1));
      checkOutput("small_busy",  32'(busy1),  expBusy(k1, N1, H1, G1));
      checkOutput("small_done",  32'(done1),  expDone(k1, N1, H1, G1));
      checkOutput("small_stage", 32'(stage1), expStage(k1, N1, H1, G1));
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset0 = 1'b1;
    req0   = 1'b0;
    reset1 = 1'b1;
    req1   = 1'b0;

    // Power-on: two reset cycles, then the full automatic sequence into idle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleCycles(20);

    // Soft request from idle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(20);

    // Abort while two banks are released.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(20);

    // Request held for twenty cycles.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(20);

    // Reset during release, reset with a simultaneous request, reset in idle.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(11);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleCycles(11);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    idleCycles(20);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    idleCycles(20);

    // Request in the very cycle the completion pulse is showing.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    idleCycles(16);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(20);

    // Randomised traffic with occasional long request bursts.
    for (int i = 0; i < 1500; i++) begin
      logic r0;
      logic q0;
      logic r1;
      logic q1;
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(1, 25);
      r0 = ($urandom_range(0, 59) == 0);
      q0 = (burst > 0) || ($urandom_range(0, 14) == 0);
      r1 = ($urandom_range(0, 29) == 0);
      q1 = ($urandom_range(0, 4) == 0);
      if (burst > 0) burst--;
      applyStimulus(r0, q0, r1, q1);
    end
    idleCycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
